// File: rtl/sevenseg_decoder.sv
// ---------------------------------------------------------------------------
// sevenseg_decoder : samples multiplexed 7-segment drive lines and decodes
//                    stable glyphs into a per-position hex value register.
// Optional blank-glyph support: `define SEVENSEG_DEC_BLANK_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sevenseg_decoder #(
  parameter int NUM_DIGITS        = 4,
  parameter int STABLE_CYCLES     = 3,
  parameter int ZERO_IS_ON        = 0,
  parameter int INVERSE_NUMBERING = 0,
  localparam int POS_W            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic [NUM_DIGITS-1:0]   in_sel,
  input  logic [6:0]              in_leds,
  output logic                    out_valid,
  output logic [3:0]              out_digit,
  output logic [POS_W-1:0]        out_pos,
  output logic                    out_err,
`ifdef SEVENSEG_DEC_BLANK_EN
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic [NUM_DIGITS-1:0]   out_blank
`else
  output logic [4*NUM_DIGITS-1:0] out_value
`endif
);

  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [NUM_DIGITS+6:0]     prev_q;
  logic                      valid_q;
  logic [3:0]                digit_q;
  logic [POS_W-1:0]          pos_q;
  logic                      err_q;
  logic [4*NUM_DIGITS-1:0]   value_q;

  logic [6:0]                leds_n;
  logic [6:0]                pat;
  logic [NUM_DIGITS+6:0]     sample;
  logic                      same;
  logic                      glyph_ok;
  logic [3:0]                glyph_digit;
  logic                      sel_any;
  logic                      sel_multi;
  logic [POS_W-1:0]          sel_idx;
  logic                      capture;

  // Normalise to p[6:0] = gfedcba regardless of polarity and bit order.
  always_comb begin
    leds_n = (ZERO_IS_ON != 0) ? ~in_leds : in_leds;
    pat    = leds_n;
    if (INVERSE_NUMBERING != 0) begin
      for (int i = 0; i < 7; i++) begin
        pat[i] = leds_n[6-i];
      end
    end
  end

  assign sample = {in_sel, pat};
  assign same   = (sample == prev_q);

  always_comb begin
    glyph_ok    = 1'b1;
    glyph_digit = 4'h0;
    case (pat)
      7'h3f: glyph_digit = 4'h0;
      7'h06: glyph_digit = 4'h1;
      7'h5b: glyph_digit = 4'h2;
      7'h4f: glyph_digit = 4'h3;
      7'h66: glyph_digit = 4'h4;
      7'h6d: glyph_digit = 4'h5;
      7'h7d: glyph_digit = 4'h6;
      7'h07: glyph_digit = 4'h7;
      7'h7f: glyph_digit = 4'h8;
      7'h6f: glyph_digit = 4'h9;
      7'h77: glyph_digit = 4'ha;
      7'h7c: glyph_digit = 4'hb;
      7'h39: glyph_digit = 4'hc;
      7'h5e: glyph_digit = 4'hd;
      7'h79: glyph_digit = 4'he;
      7'h71: glyph_digit = 4'hf;
`ifdef SEVENSEG_DEC_BLANK_EN
      7'h00: glyph_digit = 4'h0;
`endif
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    sel_any   = 1'b0;
    sel_multi = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (in_sel[i]) begin
        if (sel_any) sel_multi = 1'b1;
        sel_any = 1'b1;
        sel_idx = POS_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!same) begin
      cnt_d = 8'd0;
    end else if (cnt_q != 8'hff) begin
      cnt_d = cnt_q + 8'd1;
    end
    case (state_q)
      SETTLE: begin
        if (same && (cnt_q == STABLE_M1)) begin
          // A non-one-hot select settles silently into HOLD.
          capture = sel_any && !sel_multi;
          state_d = capture ? CAPTURE : HOLD;
        end
      end
      CAPTURE: state_d = same ? HOLD : SETTLE;
      HOLD:    if (!same) state_d = SETTLE;
      default: state_d = SETTLE;
    endcase
  end

`ifdef SEVENSEG_DEC_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q;
  assign out_blank = blank_q;
`endif

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= SETTLE;
      cnt_q   <= 8'd0;
      prev_q  <= '0;
      valid_q <= 1'b0;
      digit_q <= 4'h0;
      pos_q   <= '0;
      err_q   <= 1'b0;
      value_q <= '0;
`ifdef SEVENSEG_DEC_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= sample;
      valid_q <= capture;
      if (capture) begin
        pos_q <= sel_idx;
        if (glyph_ok) begin
          digit_q <= glyph_digit;
          err_q   <= 1'b0;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_idx == POS_W'(i)) begin
              value_q[i*4 +: 4] <= glyph_digit;
`ifdef SEVENSEG_DEC_BLANK_EN
              blank_q[i] <= (pat == 7'h00);
`endif
            end
          end
        end else begin
          digit_q <= 4'h0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_digit = digit_q;
  assign out_pos   = pos_q;
  assign out_err   = err_q;
  assign out_value = value_q;

endmodule

`default_nettype wire
